// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory port arbiter.
package mem_arb_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    D_BUSY  = 2'd2,
    RESP    = 2'd3
  } arb_state_t;

  // Grant decision taken in IDLE.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_D    = 2'd2
  } grant_t;

  localparam int unsigned DEF_MAX_D_BURST = 4;
  localparam int unsigned DEF_TIMEOUT_CYC = 64;

  // Width of the MEM burst counter: must hold 0..max_burst.
  function automatic int unsigned burst_cnt_w(input int unsigned max_burst);
    return (max_burst < 1) ? 1 : $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the IF/MEM pipeline stages, the arbiter and the memory.
//
// Handshake semantics: a requester raises *_req_i and holds address, write enable
// and write data stable until its one-cycle *_valid_o pulse; it may present its next
// request in the cycle after that pulse. Toward memory, mem_req_o is held with stable
// mem_we_o/mem_addr_o/mem_wdata_o until the one-cycle mem_ack_i (which may arrive in
// the first mem_req_o cycle); mem_rdata_i is valid only together with mem_ack_i.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic [DATA_W-1:0] if_rdata_o;
  logic              if_valid_o;
  logic              if_stall_o;
  logic              d_req_i;
  logic              d_we_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [DATA_W-1:0] d_wdata_i;
  logic [DATA_W-1:0] d_rdata_o;
  logic              d_valid_o;
  logic              d_stall_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_ack_i;
  logic              err_o;

  // Arbiter side.
  modport slave (
    input  if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i,
           mem_rdata_i, mem_ack_i,
    output if_rdata_o, if_valid_o, if_stall_o, d_rdata_o, d_valid_o, d_stall_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, err_o
  );

  // Pipeline stages and memory side.
  modport master (
    output if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i,
           mem_rdata_i, mem_ack_i,
    input  if_rdata_o, if_valid_o, if_stall_o, d_rdata_o, d_valid_o, d_stall_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, err_o
  );
endinterface

// File: rtl/mem_arb_timeout.sv
// Ack watchdog: counts enabled cycles and flags the cycle in which the
// TIMEOUT_CYC-th consecutive enabled cycle is reached.
module mem_arb_timeout #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q;

  // The first enabled cycle sees count 0, so expiry is at TIMEOUT_CYC-1.
  assign expired_o = en_i && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // Cycle counter, cleared whenever the arbiter is not waiting on memory.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !expired_o) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the IF stage (reads) and the MEM stage
// (reads/writes). MEM has priority, bounded by a burst limit so IF cannot starve.
// Optional feature macro: ARB_TIMEOUT_EN (ack watchdog with sticky err_o).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MAX_D_BURST = DEF_MAX_D_BURST,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              clk_i,
  input  logic              rst_i,
  mem_port_arbiter_if.slave bus,
  output arb_state_t        dbg_state_o
);
  localparam int unsigned BURST_W = burst_cnt_w(MAX_D_BURST);

  arb_state_t        state_q, state_d;
  grant_t            grant_w;
  logic              done_ack, done_to, wd_expired;
  logic [BURST_W-1:0] burst_q;
  logic              burst_full;

  logic              mem_req_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
  logic              if_valid_q, d_valid_q;

  assign burst_full = (burst_q == BURST_W'(MAX_D_BURST));

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state, grant decision and completion cause.
  always_comb begin
    state_d  = state_q;
    grant_w  = GNT_NONE;
    done_ack = 1'b0;
    done_to  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.d_req_i && !(bus.if_req_i && burst_full)) begin
          grant_w = GNT_D;
          state_d = D_BUSY;
        end else if (bus.if_req_i) begin
          grant_w = GNT_IF;
          state_d = IF_BUSY;
        end
      end
      IF_BUSY, D_BUSY: begin
        if (bus.mem_ack_i) begin
          done_ack = 1'b1;
          state_d  = RESP;
        end else if (wd_expired) begin
          done_to = 1'b1;
          state_d = RESP;
        end
      end
      // One dead cycle so IDLE never sees the request that just completed.
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory request registers, read data capture and completion pulses.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
    end else begin
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      if (grant_w != GNT_NONE) begin
        mem_req_q   <= 1'b1;
        mem_we_q    <= (grant_w == GNT_D) && bus.d_we_i;
        mem_addr_q  <= (grant_w == GNT_D) ? bus.d_addr_i : bus.if_addr_i;
        mem_wdata_q <= (grant_w == GNT_D) ? bus.d_wdata_i : '0;
      end
      if (done_ack || done_to) begin
        mem_req_q <= 1'b0;
        mem_we_q  <= 1'b0;
        if (state_q == IF_BUSY) begin
          if_valid_q <= 1'b1;
          if_rdata_q <= done_ack ? bus.mem_rdata_i : '0;
        end else begin
          d_valid_q <= 1'b1;
          d_rdata_q <= done_ack ? bus.mem_rdata_i : '0;
        end
      end
    end
  end

  // Consecutive MEM grants while IF waits; IF wins once this saturates.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      burst_q <= '0;
    end else if (state_q == IDLE) begin
      if (!bus.if_req_i || grant_w == GNT_IF) begin
        burst_q <= '0;
      end else if (grant_w == GNT_D && !burst_full) begin
        burst_q <= burst_q + BURST_W'(1);
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic busy;
  logic err_q;

  assign busy = (state_q == IF_BUSY) || (state_q == D_BUSY);

  mem_arb_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (!busy),
    .en_i      (busy),
    .expired_o (wd_expired)
  );

  // Sticky error once any access was abandoned by the watchdog.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)       err_q <= 1'b0;
    else if (done_to) err_q <= 1'b1;
  end

  assign bus.err_o = err_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign wd_expired         = 1'b0;
  assign bus.err_o          = 1'b0;
`endif

  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;
  assign bus.if_rdata_o  = if_rdata_q;
  assign bus.if_valid_o  = if_valid_q;
  assign bus.d_rdata_o   = d_rdata_q;
  assign bus.d_valid_o   = d_valid_q;
  assign bus.if_stall_o  = bus.if_req_i & ~if_valid_q;
  assign bus.d_stall_o   = bus.d_req_i & ~d_valid_q;
  assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized concurrent traffic,
// checked against a transaction-level arbitration model and an expected memory image.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int TB_TO   = 8;
  localparam int MAXB    = 4;
  localparam int TMO     = 200;
  localparam int NO_GNT  = 0;
  localparam int IF_GNT  = 1;
  localparam int D_GNT   = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  arb_state_t dbg_state;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_D_BURST(MAXB), .TIMEOUT_CYC(TB_TO)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_mem  [logic [31:0]];
  logic [31:0] phys_mem [logic [31:0]];
  int done_q[$];
  int ack_delay = -1;
  bit no_ack = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    return exp_mem.exists(a) ? exp_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] phys_rd(input logic [31:0] a);
    return phys_mem.exists(a) ? phys_mem[a] : init_word(a);
  endfunction

  // ---------------- memory responder ----------------
  initial begin : responder
    bit active;
    int wait_n;
    active = 1'b0;
    wait_n = 0;
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = '0;
    forever begin
      @(posedge clk); #1;
      bus.mem_ack_i = 1'b0;
      if (!rst_n || !bus.mem_req_o) begin
        active = 1'b0;
      end else begin
        if (!active) begin
          active = 1'b1;
          wait_n = (ack_delay < 0) ? int'($urandom_range(0, 3)) : ack_delay;
        end
        if (!no_ack) begin
          if (wait_n == 0) begin
            bus.mem_ack_i = 1'b1;
            if (bus.mem_we_o) begin
              phys_mem[bus.mem_addr_o] = bus.mem_wdata_o;
              bus.mem_rdata_i = $urandom;
            end else begin
              bus.mem_rdata_i = phys_rd(bus.mem_addr_o);
            end
          end else begin
            wait_n--;
          end
        end
      end
    end
  end

  // ---------------- transaction-level arbitration monitor ----------------
  initial begin : monitor
    int cur, cnt, low_cnt, busy_cnt, win;
    bit nxt_if_v, nxt_d_v, nxt_err, exp_if_v, exp_d_v, exp_err, ended_prev;
    bit p_if_req, p_d_req, p_d_we, p_mem_req;
    logic [31:0] p_if_addr, p_d_addr, p_d_wdata;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cur = NO_GNT; cnt = 0; low_cnt = 99; busy_cnt = 0;
        nxt_if_v = 0; nxt_d_v = 0; nxt_err = 0; exp_err = 0; ended_prev = 0;
        p_mem_req = 0;
      end else begin
        exp_if_v = nxt_if_v; exp_d_v = nxt_d_v;
        nxt_if_v = 0; nxt_d_v = 0;
        exp_err = exp_err | nxt_err;
        check("if_valid", bus.if_valid_o, exp_if_v);
        check("d_valid", bus.d_valid_o, exp_d_v);
        check("if_stall", bus.if_stall_o, bus.if_req_i & ~exp_if_v);
        check("d_stall", bus.d_stall_o, bus.d_req_i & ~exp_d_v);
        check("err", bus.err_o, exp_err);
        if (ended_prev) check("req_drop", bus.mem_req_o, 0);
        ended_prev = 0;
        if (bus.mem_req_o && !p_mem_req) begin
          check("req_gap_ge2", low_cnt >= 2, 1);
          check("gnt_has_req", p_if_req | p_d_req, 1);
          win = (p_d_req && !(p_if_req && cnt == MAXB)) ? D_GNT : IF_GNT;
          if (win == D_GNT) begin
            check("gnt_d_addr", bus.mem_addr_o, p_d_addr);
            check("gnt_d_we", bus.mem_we_o, p_d_we);
            if (p_d_we) check("gnt_d_wdata", bus.mem_wdata_o, p_d_wdata);
            if (p_if_req && cnt < MAXB) cnt++;
          end else begin
            check("gnt_if_addr", bus.mem_addr_o, p_if_addr);
            check("gnt_if_we", bus.mem_we_o, 0);
            cnt = 0;
          end
          cur = win;
          busy_cnt = 0;
        end
        if (bus.mem_req_o) begin
          low_cnt = 0;
          busy_cnt++;
          if (bus.mem_ack_i) begin
            nxt_if_v = (cur == IF_GNT); nxt_d_v = (cur == D_GNT); ended_prev = 1;
          end
`ifdef ARB_TIMEOUT_EN
          else if (busy_cnt == TB_TO) begin
            nxt_if_v = (cur == IF_GNT); nxt_d_v = (cur == D_GNT);
            nxt_err = 1; ended_prev = 1;
          end
`endif
        end else begin
          low_cnt++;
        end
        if (bus.if_req_i && !p_if_req) cnt = 0;
      end
      p_if_req = bus.if_req_i; p_if_addr = bus.if_addr_i;
      p_d_req = bus.d_req_i; p_d_we = bus.d_we_i;
      p_d_addr = bus.d_addr_i; p_d_wdata = bus.d_wdata_i;
      p_mem_req = bus.mem_req_o;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic if_txn(input logic [31:0] addr, input int gap, input bit exp_zero,
                        output int lat);
    repeat (gap) @(posedge clk);
    #1;
    bus.if_req_i = 1'b1;
    bus.if_addr_i = addr;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!bus.if_valid_o && lat < TMO);
    check("if_done", bus.if_valid_o, 1);
    if (bus.if_valid_o) check("if_rdata", bus.if_rdata_o, exp_zero ? 32'h0 : exp_rd(addr));
    done_q.push_back(IF_GNT);
    @(posedge clk); #1;
    bus.if_req_i = 1'b0;
  endtask

  task automatic d_txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       input int gap, output int lat);
    repeat (gap) @(posedge clk);
    #1;
    bus.d_req_i = 1'b1;
    bus.d_we_i = we;
    bus.d_addr_i = addr;
    bus.d_wdata_i = wdata;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!bus.d_valid_o && lat < TMO);
    check("d_done", bus.d_valid_o, 1);
    if (bus.d_valid_o) begin
      if (we) exp_mem[addr] = wdata;
      else    check("d_rdata", bus.d_rdata_o, exp_rd(addr));
    end
    done_q.push_back(D_GNT);
    @(posedge clk); #1;
    bus.d_req_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_req"}, bus.mem_req_o, 0);
    check({tag, "_mem_we"}, bus.mem_we_o, 0);
    check({tag, "_mem_addr"}, bus.mem_addr_o, 0);
    check({tag, "_mem_wdata"}, bus.mem_wdata_o, 0);
    check({tag, "_if_valid"}, bus.if_valid_o, 0);
    check({tag, "_d_valid"}, bus.d_valid_o, 0);
    check({tag, "_if_rdata"}, bus.if_rdata_o, 0);
    check({tag, "_d_rdata"}, bus.d_rdata_o, 0);
    check({tag, "_err"}, bus.err_o, 0);
    check({tag, "_state_idle"}, dbg_state == IDLE, 1);
  endtask

  // ---------------- global time limit ----------------
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "time limit");
  end

  // ---------------- test sequence ----------------
  initial begin
    int l1, l2, if_pos;
    bus.if_req_i = 0; bus.if_addr_i = '0;
    bus.d_req_i = 0; bus.d_we_i = 0; bus.d_addr_i = '0; bus.d_wdata_i = '0;
    exp_mem[32'h40] = 32'h8C02_0000;
    phys_mem[32'h40] = 32'h8C02_0000;

    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // IF read alone, ack two cycles after mem_req_o
    ack_delay = 2;
    if_txn(32'h40, 1, 0, l1);
    check("if_alone_lat", l1, 5);

    // Simultaneous MEM write and IF read: MEM first
    ack_delay = -1;
    done_q.delete();
    fork
      d_txn(1, 32'h100, 32'hA5A5_A5A5, 0, l1);
      if_txn(32'h44, 0, 0, l2);
    join
    check("simul_first_d", done_q[0], D_GNT);
    check("simul_second_if", done_q[1], IF_GNT);
    d_txn(0, 32'h100, '0, 1, l1);

    // Starvation guard: 4 MEM grants, then IF, then MEM again
    done_q.delete();
    fork
      for (int i = 0; i < 6; i++) d_txn(1'($urandom), 32'h200 + 4 * i, $urandom, 0, l1);
      if_txn(32'h48, 0, 0, l2);
    join
    check("burst_count", done_q.size(), 7);
    if_pos = -1;
    foreach (done_q[i]) if (done_q[i] == IF_GNT && if_pos < 0) if_pos = i;
    check("burst_if_slot", if_pos, MAXB);
    check("burst_d_resumes", done_q[MAXB+1], D_GNT);

    // Back-to-back with ack in the first request cycle
    repeat (2) @(posedge clk);
    ack_delay = 0;
    d_txn(0, 32'h100, '0, 0, l1);
    check("b2b_lat_0", l1, 3);
    d_txn(1, 32'h104, 32'h1234_5678, 0, l1);
    check("b2b_lat_1", l1, 3);
    if_txn(32'h104, 0, 0, l1);
    check("b2b_lat_2", l1, 3);

    // Reset in the middle of a MEM access
    no_ack = 1'b1;
    @(posedge clk); #1;
    bus.d_req_i = 1; bus.d_we_i = 1; bus.d_addr_i = 32'h300; bus.d_wdata_i = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    check("pre_rst_busy", bus.mem_req_o, 1);
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("mid_rst");
    bus.d_req_i = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    no_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_idle_req", bus.mem_req_o, 0);
    end

`ifdef ARB_TIMEOUT_EN
    // Watchdog: no ack at all
    no_ack = 1'b1;
    if_txn(32'h80, 0, 1, l1);
    check("to_lat", l1, TB_TO + 2);
    check("to_err_set", bus.err_o, 1);
    no_ack = 1'b0;
    ack_delay = -1;
    d_txn(0, 32'h40, '0, 1, l1);
    @(negedge clk);
    check("to_err_sticky", bus.err_o, 1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("to_err_cleared", bus.err_o, 0);
`endif

    // Randomized concurrent traffic
    ack_delay = -1;
    fork
      for (int i = 0; i < 30; i++)
        if_txn(32'h100 + 4 * $urandom_range(0, 15), $urandom_range(0, 3), 0, l1);
      for (int i = 0; i < 30; i++)
        d_txn(1'($urandom), 32'h100 + 4 * $urandom_range(0, 15), $urandom,
              $urandom_range(0, 3), l2);
    join
    repeat (4) @(negedge clk);
    check("final_idle", dbg_state == IDLE, 1);
    check("final_no_req", bus.mem_req_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
